regpair_sequencer: RTL

REGPAIR_SEQUENCER -- requirements
Module: regpair_sequencer

---
 rtl/regpair_sequencer.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/regpair_sequencer.sv
// Register-pair sequencer: READ/LOAD/INC/DEC of 16-bit pairs held in an external 8-entry file.
// Optional macro REGSEQ_WRAPFLAG_EN builds the INC/DEC wrap flag; otherwise resp_wrap is tied 0.
module regpair_sequencer #(
  parameter int unsigned DATASIZE = 8,
  parameter int unsigned ADDRSIZE = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [1:0]            cmd_pair,
  input  logic [2*DATASIZE-1:0] cmd_data,
  output logic                  wrenb,
  output logic [ADDRSIZE-1:0]   waddr,
  output logic [DATASIZE-1:0]   wdata,
  output logic                  r1enb,
  output logic [ADDRSIZE-1:0]   r1add,
  output logic                  r2enb,
  output logic [ADDRSIZE-1:0]   r2add,
  input  logic [DATASIZE-1:0]   r1dat,
  input  logic [DATASIZE-1:0]   r2dat,
  output logic                  resp_valid,
  output logic [2*DATASIZE-1:0] resp_data,
  output logic                  resp_err,
  output logic                  resp_wrap
);

  localparam int unsigned PW = 2 * DATASIZE;

  localparam logic [1:0] OpRead = 2'b00;
  localparam logic [1:0] OpLoad = 2'b01;
  localparam logic [1:0] OpInc  = 2'b10;
  localparam logic [1:0] OpDec  = 2'b11;

  typedef enum logic [2:0] {StIdle, StRd, StWrl, StWrh, StDone} state_e;

  state_e            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [1:0]        pair_q, pair_d;
  logic [PW-1:0]     val_q, val_d;
  logic              err_q, err_d;
  logic [PW-1:0]     resp_data_q;
  logic              resp_err_q;
  logic [PW-1:0]     rd_val;
  logic [ADDRSIZE-1:0] hi_addr, lo_addr;

  assign rd_val  = {r1dat, r2dat};
  assign hi_addr = ADDRSIZE'({pair_q, 1'b0});
  assign lo_addr = ADDRSIZE'({pair_q, 1'b1});

`ifdef REGSEQ_WRAPFLAG_EN
  logic wrap_q, wrap_d;
  logic resp_wrap_q;
`endif

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    pair_d     = pair_q;
    val_d      = val_q;
    err_d      = err_q;
`ifdef REGSEQ_WRAPFLAG_EN
    wrap_d     = wrap_q;
`endif
    cmd_ready  = 1'b0;
    wrenb      = 1'b0;
    waddr      = '0;
    wdata      = '0;
    r1enb      = 1'b0;
    r1add      = '0;
    r2enb      = 1'b0;
    r2add      = '0;
    resp_valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Held low while reset is asserted so nothing is accepted during reset.
        cmd_ready = rst;
        if (cmd_valid && rst) begin
          op_d   = cmd_op;
          pair_d = cmd_pair;
          val_d  = cmd_data;
          err_d  = 1'b0;
`ifdef REGSEQ_WRAPFLAG_EN
          wrap_d = 1'b0;
`endif
          if (cmd_pair == 2'd3 && cmd_op != OpRead) begin
            err_d   = 1'b1;
            val_d   = '0;
            state_d = StDone;
          end else if (cmd_op == OpLoad) begin
            state_d = StWrl;
          end else begin
            state_d = StRd;
          end
        end
      end
      StRd: begin
        r1enb = 1'b1;
        r1add = hi_addr;
        r2enb = 1'b1;
        r2add = lo_addr;
        case (op_q)
          OpInc:   val_d = rd_val + PW'(1);
          OpDec:   val_d = rd_val - PW'(1);
          default: val_d = rd_val;
        endcase
`ifdef REGSEQ_WRAPFLAG_EN
        wrap_d = ((op_q == OpInc) && (&rd_val)) || ((op_q == OpDec) && !(|rd_val));
`endif
        state_d = (op_q == OpRead) ? StDone : StWrl;
      end
      StWrl: begin
        wrenb   = 1'b1;
        waddr   = lo_addr;
        wdata   = val_q[DATASIZE-1:0];
        state_d = StWrh;
      end
      StWrh: begin
        wrenb   = 1'b1;
        waddr   = hi_addr;
        wdata   = val_q[PW-1:DATASIZE];
        state_d = StDone;
      end
      StDone: begin
        resp_valid = 1'b1;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      op_q        <= OpRead;
      pair_q      <= 2'd0;
      val_q       <= '0;
      err_q       <= 1'b0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      pair_q  <= pair_d;
      val_q   <= val_d;
      err_q   <= err_d;
      // Response fields update only on entry to DONE and hold until the next one.
      if (state_d == StDone) begin
        resp_data_q <= val_d;
        resp_err_q  <= err_d;
      end
    end
  end

`ifdef REGSEQ_WRAPFLAG_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrap_q      <= 1'b0;
      resp_wrap_q <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
      if (state_d == StDone) begin
        resp_wrap_q <= wrap_d;
      end
    end
  end
  assign resp_wrap = resp_wrap_q;
`else
  assign resp_wrap = 1'b0;
`endif

  assign resp_data = resp_data_q;
  assign resp_err  = resp_err_q;

endmodule
